// File: rtl/fb_pkg.sv
// Frame-buffer access scheduler shared types and constants.
// Default geometry, widths and the swap FSM encoding live here.
package fb_pkg;

  localparam int FB_DATA_W  = 8;
  localparam int FB_HORIZ   = 640;
  localparam int FB_VERT    = 480;
  localparam int FB_ADDR_W  = 19;
  localparam int FB_WFIFO_D = 4;
  localparam int FB_PIXELS  = FB_HORIZ * FB_VERT;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } wr_entry_t;

  typedef logic page_t;

  typedef enum logic [1:0] {
    SW_IDLE,
    SW_PENDING,
    SW_SWAP
  } swap_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Host write FIFO: registered storage, wrap-bit pointers.
// Accepts a push while full only when an entry pops that cycle.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = clog2(DEPTH);

  logic [PW:0]      wp_q, wp_d;
  logic [PW:0]      rp_q, rp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[PW] != rp_q[PW]) &&
                 (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign dout  = mem_q[rp_q[PW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointers and storage contents.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wp_q[PW-1:0]] = din;
      wp_d = wp_q + 1'b1;
    end
    if (do_pop) rp_d = rp_q + 1'b1;
  end

  // Pointer and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/fb_access_scheduler.sv
// Single-port double-buffered frame RAM arbiter: scan-out reads
// in active video, host writes drain in blanking, vblank page swap.
module fb_access_scheduler
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH  = FB_DATA_W,
  parameter int HORIZ       = FB_HORIZ,
  parameter int VERT        = FB_VERT,
  parameter int ADDR_WIDTH  = FB_ADDR_W,
  parameter int WFIFO_DEPTH = FB_WFIFO_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  video_on,
  input  logic                  vblank_start,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  swap_done,
  output logic                  disp_page,
  output logic                  wr_oob,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] rgb_data
);

  localparam int PIXELS = HORIZ * VERT;
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX =
    ADDR_WIDTH'(PIXELS - 1);
  localparam logic [ADDR_WIDTH:0] PIX_LIM =
    (ADDR_WIDTH + 1)'(PIXELS);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  page_t                 disp_page_q, disp_page_d;
  swap_state_e           state_q, state_d;
  logic                  oob_q, oob_d;
  logic                  vo_q, vo_d;
  logic [DATA_WIDTH-1:0] rgb_q, rgb_d;

  entry_t head;
  entry_t wr_entry;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  logic   head_oob;

  assign wr_entry = '{addr: wr_addr, data: wr_data};
  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready;
  assign head_oob = ({1'b0, head.addr} >= PIX_LIM);

  fb_wr_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (WFIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // RAM port mux: scan-out owns the port during active video.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pop       = 1'b0;
    oob_d     = oob_q;
    if (video_on) begin
      mem_re   = 1'b1;
      mem_addr = {disp_page_q, rd_cnt_q};
    end else if (!empty) begin
      pop = 1'b1;
      if (head_oob) begin
        oob_d = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_addr  = {~disp_page_q, head.addr};
        mem_wdata = head.data;
      end
    end
  end

  // Scan-out address: resync on vblank, wrap at the last pixel.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (vblank_start) begin
      rd_cnt_d = '0;
    end else if (video_on) begin
      if (rd_cnt_q == LAST_PIX) rd_cnt_d = '0;
      else                      rd_cnt_d = rd_cnt_q + 1'b1;
    end
  end

  // Swap FSM: only swap at vblank once queued writes have landed.
  always_comb begin
    state_d     = state_q;
    disp_page_d = disp_page_q;
    unique case (state_q)
      SW_IDLE: begin
        if (swap_req) state_d = SW_PENDING;
      end
      SW_PENDING: begin
        if (vblank_start && empty && !push) begin
          state_d     = SW_SWAP;
          disp_page_d = ~disp_page_q;
        end
      end
      SW_SWAP: state_d = SW_IDLE;
      default: state_d = SW_IDLE;
    endcase
  end

  // Output pipe: pixel lands two cycles after its read.
  always_comb begin
    vo_d  = video_on;
    rgb_d = vo_q ? mem_rdata : '0;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q    <= '0;
      disp_page_q <= 1'b0;
      state_q     <= SW_IDLE;
      oob_q       <= 1'b0;
      vo_q        <= 1'b0;
      rgb_q       <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      disp_page_q <= disp_page_d;
      state_q     <= state_d;
      oob_q       <= oob_d;
      vo_q        <= vo_d;
      rgb_q       <= rgb_d;
    end
  end

  assign swap_pending = (state_q == SW_PENDING);
  assign swap_done    = (state_q == SW_SWAP);
  assign disp_page    = disp_page_q;
  assign wr_oob       = oob_q;
  assign rgb_data     = rgb_q;

endmodule
